// File: rtl/inputconditioner_multi.sv
// inputconditioner_multi: per-lane synchroniser, debouncer and edge detector with aggregate edge flag
// Optional per-lane glitch counters are built when INPUTCOND_GLITCH_COUNT_EN is defined.
module inputconditioner_multi #(
  parameter int CHANNELS = 8,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_TIME = 3,
  parameter logic [CHANNELS-1:0] RESET_VALUE = {CHANNELS{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   noisysignal,
`ifdef INPUTCOND_GLITCH_COUNT_EN
  input  logic                  glitch_clear,
  output logic [CHANNELS*4-1:0] glitch_count,
`endif
  output logic [CHANNELS-1:0]   conditioned,
  output logic [CHANNELS-1:0]   positiveedge,
  output logic [CHANNELS-1:0]   negativeedge,
  output logic                  anyedge
);
  localparam int CNT_W = $clog2(WAIT_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_TIME - 1);
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q [CHANNELS];
  logic [CNT_W-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0] s, flip;
  assign s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VALUE;
    end else begin
      sync_q[0] <= noisysignal;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  // a lane flips once its synchronised level has differed for WAIT_TIME consecutive cycles
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign flip[i]  = s[i] != conditioned[i] && cnt_q[i] == CNT_MAX;
    assign cnt_d[i] = (s[i] == conditioned[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      conditioned  <= RESET_VALUE;
      positiveedge <= '0;
      negativeedge <= '0;
      anyedge      <= 1'b0;
      cnt_q        <= '{default: '0};
    end else begin
      conditioned  <= conditioned ^ flip;
      positiveedge <= flip & s;
      negativeedge <= flip & ~s;
      anyedge      <= |flip;
      cnt_q        <= cnt_d;
    end
`ifdef INPUTCOND_GLITCH_COUNT_EN
  logic [3:0] gc_q [CHANNELS];
  logic [CHANNELS-1:0] abort;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_glitch
    assign abort[i] = s[i] == conditioned[i] && cnt_q[i] != '0;
    assign glitch_count[4*i +: 4] = gc_q[i];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gc_q <= '{default: '0};
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        gc_q[k] <= glitch_clear ? 4'd0 : (abort[k] && gc_q[k] != 4'hF) ? gc_q[k] + 4'd1 : gc_q[k];
    end
`endif
endmodule

// File: tb/tb_inputconditioner_multi.sv
// tb_inputconditioner_multi: randomized and directed checks of inputconditioner_multi against a window-based reference model
module tb_inputconditioner_multi;
  localparam int N = 8, S = 2, W = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] noisysignal, conditioned, positiveedge, negativeedge;
  logic anyedge;
`ifdef INPUTCOND_GLITCH_COUNT_EN
  logic glitch_clear = 1'b0;
  logic [31:0] glitch_count;
`endif
  always #5 clk = ~clk;

  inputconditioner_multi dut (
    .clk(clk),
    .reset(reset),
    .noisysignal(noisysignal),
`ifdef INPUTCOND_GLITCH_COUNT_EN
    .glitch_clear(glitch_clear),
    .glitch_count(glitch_count),
`endif
    .conditioned(conditioned),
    .positiveedge(positiveedge),
    .negativeedge(negativeedge),
    .anyedge(anyedge)
  );

  int vec = 0, errs = 0;
  logic [7:0] in_q[$];
  logic [7:0] m_cond, m_pos, m_neg;
  logic m_any;
  int last_flip[N];
  int gc[N];
  logic gclr = 1'b0;

  // input sampled at post-reset edge k (edges before the first one see the reset value)
  function automatic logic [7:0] inp(input int k);
    return (k >= 1) ? in_q[k-1] : 8'h00;
  endfunction

`ifdef INPUTCOND_GLITCH_COUNT_EN
  function automatic logic [31:0] m_gc();
    logic [31:0] r;
    for (int l = 0; l < N; l++) r[4*l +: 4] = 4'(gc[l]);
    return r;
  endfunction
`endif

  task automatic model_reset();
    in_q = {};
    m_cond = 8'h00; m_pos = 8'h00; m_neg = 8'h00; m_any = 1'b0;
    for (int l = 0; l < N; l++) begin last_flip[l] = 0; gc[l] = 0; end
  endtask

  // drives one cycle and advances the model; a lane changes at edge n when the synchronised
  // level s(j) = input(j-S) differed from the output at every edge of the W-wide window ending at n,
  // all of it after the lane's previous change
  task automatic tick(input logic [7:0] v);
    int n;
    bit ok, ab;
    logic [7:0] t, sn, sp;
    noisysignal = v;
`ifdef INPUTCOND_GLITCH_COUNT_EN
    glitch_clear = gclr;
`endif
    @(posedge clk);
    in_q.push_back(v);
    n = in_q.size();
    m_pos = 8'h00; m_neg = 8'h00;
    sn = inp(n - S);
    sp = inp(n - 1 - S);
    for (int l = 0; l < N; l++) begin
      ok = 1'b1;
      for (int j = n - W + 1; j <= n; j++) begin
        t = inp(j - S);
        if (j < 1 || j <= last_flip[l] || t[l] == m_cond[l]) ok = 1'b0;
      end
      ab = sn[l] == m_cond[l] && (n - 1) > last_flip[l] && sp[l] != m_cond[l];
      gc[l] = gclr ? 0 : (ab && gc[l] < 15) ? gc[l] + 1 : gc[l];
      if (ok) begin
        m_pos[l] = ~m_cond[l];
        m_neg[l] = m_cond[l];
        m_cond[l] = ~m_cond[l];
        last_flip[l] = n;
      end
    end
    m_any = |(m_pos | m_neg);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    noisysignal = 8'hFF;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({conditioned, positiveedge, negativeedge, anyedge} !== 25'h0) begin
      errs++; $display("FAIL reset_state: got c=%h p=%h n=%h a=%b want all zero", conditioned, positiveedge, negativeedge, anyedge);
    end
    reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 7; e++) begin
      tick(8'hFF);
      vec++;
      if ({conditioned, positiveedge, negativeedge, anyedge} !== {m_cond, m_pos, m_neg, m_any}) begin
        errs++; $display("FAIL reset_model e%0d: got c=%h p=%h n=%h a=%b want c=%h p=%h n=%h a=%b", e, conditioned, positiveedge, negativeedge, anyedge, m_cond, m_pos, m_neg, m_any);
      end
      vec++;
      if (conditioned !== (e >= 5 ? 8'hFF : 8'h00) || positiveedge !== (e == 5 ? 8'hFF : 8'h00) || anyedge !== (e == 5) || negativeedge !== 8'h00) begin
        errs++; $display("FAIL reset_latency e%0d: got c=%h p=%h n=%h a=%b", e, conditioned, positiveedge, negativeedge, anyedge);
      end
    end
    #2 reset = 1'b1;
    #1;
    vec++;
    if (conditioned !== 8'h00 || anyedge !== 1'b0) begin
      errs++; $display("FAIL async_reset: got c=%h a=%b want c=00 a=0", conditioned, anyedge);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      tick(e <= 2 ? 8'h01 : 8'h00);
      vec++;
      if ({conditioned, positiveedge, negativeedge, anyedge} !== {m_cond, m_pos, m_neg, m_any} || conditioned[0] !== 1'b0 || anyedge !== 1'b0) begin
        errs++; $display("FAIL glitch e%0d: got c=%h p=%h n=%h a=%b want c=%h p=%h n=%h a=%b", e, conditioned, positiveedge, negativeedge, anyedge, m_cond, m_pos, m_neg, m_any);
      end
    end
`ifdef INPUTCOND_GLITCH_COUNT_EN
    vec++;
    if (glitch_count[3:0] !== 4'd1 || glitch_count !== m_gc()) begin
      errs++; $display("FAIL glitch_count: got %h want lane0=1 model %h", glitch_count, m_gc());
    end
`endif
  endtask

  task automatic test_bounce();
    int npos = 0, nneg = 0, pos_at = -1;
    logic [7:0] seq [5] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h08};
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      tick(e <= 5 ? seq[e-1] : 8'h08);
      if (positiveedge[3]) begin npos++; pos_at = e; end
      if (negativeedge[3]) nneg++;
      vec++;
      if ({conditioned, positiveedge, negativeedge, anyedge} !== {m_cond, m_pos, m_neg, m_any}) begin
        errs++; $display("FAIL bounce e%0d: got c=%h p=%h n=%h a=%b want c=%h p=%h n=%h a=%b", e, conditioned, positiveedge, negativeedge, anyedge, m_cond, m_pos, m_neg, m_any);
      end
    end
    vec++;
    if (npos != 1 || pos_at != 9 || nneg != 0) begin
      errs++; $display("FAIL bounce_pulses: got pos=%0d at e%0d neg=%0d want pos=1 at e9 neg=0", npos, pos_at, nneg);
    end
  endtask

  task automatic test_independence();
    do_reset();
    repeat (6) tick(8'h02);
    vec++;
    if (conditioned !== 8'h02) begin
      errs++; $display("FAIL indep_setup: got c=%h want 02", conditioned);
    end
    for (int e = 1; e <= 6; e++) begin
      tick(8'h40);
      vec++;
      if (negativeedge !== (e == 5 ? 8'h02 : 8'h00) || positiveedge !== (e == 5 ? 8'h40 : 8'h00) || conditioned !== (e >= 5 ? 8'h40 : 8'h02) || anyedge !== (e == 5)) begin
        errs++; $display("FAIL indep e%0d: got c=%h p=%h n=%h a=%b", e, conditioned, positiveedge, negativeedge, anyedge);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(8'h04);
    tick(8'h04);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vec++;
    if (conditioned !== 8'h00 || positiveedge !== 8'h00 || anyedge !== 1'b0) begin
      errs++; $display("FAIL reset_mid: got c=%h p=%h a=%b want 00 00 0", conditioned, positiveedge, anyedge);
    end
    reset = 1'b0;
    model_reset();
    for (int e = 1; e <= 6; e++) begin
      tick(8'h04);
      vec++;
      if (conditioned !== (e >= 5 ? 8'h04 : 8'h00) || positiveedge !== (e == 5 ? 8'h04 : 8'h00) || {conditioned, positiveedge, negativeedge, anyedge} !== {m_cond, m_pos, m_neg, m_any}) begin
        errs++; $display("FAIL reset_mid_rise e%0d: got c=%h p=%h n=%h a=%b want c=%h p=%h", e, conditioned, positiveedge, negativeedge, anyedge, m_cond, m_pos);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] cur = 8'h00;
    int n = 0;
    int last_pulse[N];
    do_reset();
    for (int l = 0; l < N; l++) last_pulse[l] = -100;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        do_reset();
        n = 0;
        for (int l = 0; l < N; l++) last_pulse[l] = -100;
      end
      cur ^= (c < 300) ? 8'($urandom & $urandom) : 8'($urandom & $urandom & $urandom);
      gclr = ($urandom_range(0, 15) == 0);
      tick(cur);
      gclr = 1'b0;
      n++;
      vec++;
      if ({conditioned, positiveedge, negativeedge, anyedge} !== {m_cond, m_pos, m_neg, m_any}) begin
        errs++; $display("FAIL random c%0d: got c=%h p=%h n=%h a=%b want c=%h p=%h n=%h a=%b", c, conditioned, positiveedge, negativeedge, anyedge, m_cond, m_pos, m_neg, m_any);
      end
`ifdef INPUTCOND_GLITCH_COUNT_EN
      vec++;
      if (glitch_count !== m_gc()) begin
        errs++; $display("FAIL random_gc c%0d: got %h want %h", c, glitch_count, m_gc());
      end
`endif
      for (int l = 0; l < N; l++)
        if (positiveedge[l] || negativeedge[l]) begin
          vec++;
          if ((positiveedge[l] && negativeedge[l]) || n - last_pulse[l] < W) begin
            errs++; $display("FAIL separation lane%0d c%0d: got gap %0d p=%b n=%b want gap>=%0d single pulse", l, c, n - last_pulse[l], positiveedge[l], negativeedge[l], W);
          end
          last_pulse[l] = n;
        end
    end
  endtask

`ifdef INPUTCOND_GLITCH_COUNT_EN
  task automatic test_saturation();
    do_reset();
    repeat (20) begin tick(8'h20); tick(8'h00); tick(8'h00); end
    tick(8'h00);
    vec++;
    if (glitch_count[23:20] !== 4'd15 || glitch_count !== m_gc()) begin
      errs++; $display("FAIL saturation: got %h want lane5=f model %h", glitch_count, m_gc());
    end
    tick(8'h20); tick(8'h00); tick(8'h00);
    gclr = 1'b1;
    tick(8'h00);
    gclr = 1'b0;
    vec++;
    if (glitch_count !== 32'h0 || m_gc() !== 32'h0) begin
      errs++; $display("FAIL clear_priority: got %h want 0", glitch_count);
    end
  endtask
`endif

  initial begin
    noisysignal = 8'h00;
    model_reset();
    test_reset();
    test_glitch();
    test_bounce();
    test_independence();
    test_reset_mid();
    test_random();
`ifdef INPUTCOND_GLITCH_COUNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
